// File: rtl/fetch_buf_pkg.sv
// fetch_buf shared types: payload widths and the stored entry layout.
// Payload widths mirror the ncpu64k configuration.
package fetch_buf_pkg;

  localparam int PC_W         = 32;
  localparam int BPU_UPD_W    = 16;
  localparam int NCPU_INSN_DW = 32;
  localparam int FB_ENTRY_W   = 1 + BPU_UPD_W + PC_W + NCPU_INSN_DW;

  typedef struct packed {
    logic                    exc;
    logic [BPU_UPD_W-1:0]    upd;
    logic [PC_W-1:0]         pc;
    logic [NCPU_INSN_DW-1:0] insn;
  } fb_entry_t;

endpackage

// File: rtl/fetch_buf_compact.sv
// Prefix-sum of a slot mask: per-slot packed offset and total popcount.
// Pure combinational; shared by the enqueue packer and dequeue counter.
module fetch_buf_compact #(
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]    mask_i,
  output logic [N*CW-1:0] offs_o,
  output logic [CW-1:0]   total_o
);

  logic [CW-1:0] acc;

  always_comb begin
    acc    = '0;
    offs_o = '0;
    for (int i = 0; i < N; i++) begin
      offs_o[i*CW +: CW] = acc;
      acc = acc + CW'(mask_i[i]);
    end
  end

  assign total_o = acc;

endmodule

// File: rtl/fetch_buf.sv
// Fetch buffer: packs valid fetch slots into a circular queue and
// presents the oldest entries to decode; flush empties it.
module fetch_buf
  import fetch_buf_pkg::*;
#(
  parameter int CONFIG_P_FETCH_WIDTH = 1,
  parameter int CONFIG_P_ISSUE_WIDTH = 1,
  parameter int CONFIG_P_DEPTH       = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [(1<<CONFIG_P_FETCH_WIDTH)-1:0]            push_valid,
  input  logic [(1<<CONFIG_P_FETCH_WIDTH)*NCPU_INSN_DW-1:0] push_insn,
  input  logic [(1<<CONFIG_P_FETCH_WIDTH)*PC_W-1:0]       push_pc,
  input  logic [(1<<CONFIG_P_FETCH_WIDTH)*BPU_UPD_W-1:0]  push_upd,
  input  logic [(1<<CONFIG_P_FETCH_WIDTH)-1:0]            push_exc,
  output logic                              push_ready,
  output logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]            pop_valid,
  output logic [(1<<CONFIG_P_ISSUE_WIDTH)*NCPU_INSN_DW-1:0] pop_insn,
  output logic [(1<<CONFIG_P_ISSUE_WIDTH)*PC_W-1:0]       pop_pc,
  output logic [(1<<CONFIG_P_ISSUE_WIDTH)*BPU_UPD_W-1:0]  pop_upd,
  output logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]            pop_exc,
  input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]            pop_ready,
  output logic [CONFIG_P_DEPTH:0]           count
);

  localparam int FW  = 1 << CONFIG_P_FETCH_WIDTH;
  localparam int IW  = 1 << CONFIG_P_ISSUE_WIDTH;
  localparam int D   = 1 << CONFIG_P_DEPTH;
  localparam int AW  = CONFIG_P_DEPTH;
  localparam int PW  = AW + 1;
  localparam int FCW = $clog2(FW + 1);
  localparam int ICW = $clog2(IW + 1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  fb_entry_t     mem_q [D];

  logic [FW*FCW-1:0] push_offs;
  logic [FCW-1:0]    push_cnt;
  logic              fire;
  logic [IW-1:0]     pop_lead;
  logic [IW*ICW-1:0] pop_offs_unused;
  logic [ICW-1:0]    npop;

  logic [AW-1:0] widx  [FW];
  fb_entry_t     wslot [FW];
  logic [D-1:0]  we;
  fb_entry_t     wdat  [D];
  logic [AW-1:0] ridx  [IW];

  assign count      = tail_q - head_q;
  assign push_ready = (count <= PW'(D - FW));
  assign fire       = push_ready & (|push_valid) & ~flush;

  fetch_buf_compact #(.N(FW), .CW(FCW)) u_push_cmp (
    .mask_i  (push_valid),
    .offs_o  (push_offs),
    .total_o (push_cnt)
  );

  // Only the unbroken run of accepted slots from slot 0 dequeues.
  always_comb begin
    logic run;
    run = 1'b1;
    for (int k = 0; k < IW; k++) begin
      run         = run & pop_valid[k] & pop_ready[k];
      pop_lead[k] = run;
    end
  end

  fetch_buf_compact #(.N(IW), .CW(ICW)) u_pop_cmp (
    .mask_i  (pop_lead),
    .offs_o  (pop_offs_unused),
    .total_o (npop)
  );

  always_comb begin
    head_d = head_q + PW'(npop);
    tail_d = tail_q + (fire ? PW'(push_cnt) : '0);
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < FW; i++) begin
      wslot[i].exc  = push_exc[i];
      wslot[i].upd  = push_upd[i*BPU_UPD_W +: BPU_UPD_W];
      wslot[i].pc   = push_pc[i*PC_W +: PC_W];
      wslot[i].insn = push_insn[i*NCPU_INSN_DW +: NCPU_INSN_DW];
      widx[i] = tail_q[AW-1:0] + AW'(push_offs[i*FCW +: FCW]);
    end
  end

  // Valid slots get distinct offsets, so at most one slot hits an entry.
  always_comb begin
    we = '0;
    for (int e = 0; e < D; e++) begin
      wdat[e] = '0;
      for (int i = 0; i < FW; i++) begin
        if (fire && push_valid[i] && widx[i] == AW'(e)) begin
          we[e]   = 1'b1;
          wdat[e] = wslot[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < D; e++) begin
      if (we[e]) mem_q[e] <= wdat[e];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_comb begin
    for (int k = 0; k < IW; k++) begin
      ridx[k]      = head_q[AW-1:0] + AW'(k);
      pop_valid[k] = (count > PW'(k));
      pop_exc[k]   = mem_q[ridx[k]].exc;
      pop_upd[k*BPU_UPD_W +: BPU_UPD_W] = mem_q[ridx[k]].upd;
      pop_pc[k*PC_W +: PC_W]            = mem_q[ridx[k]].pc;
      pop_insn[k*NCPU_INSN_DW +: NCPU_INSN_DW] = mem_q[ridx[k]].insn;
    end
  end

endmodule

// File: tb/tb_fetch_buf.sv
// Directed self-checking bench for fetch_buf (FW=2, IW=2, D=8).
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_fetch_buf;
  import fetch_buf_pkg::*;

  localparam int FW = 2;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [FW-1:0]        push_valid = '0;
  logic [FW*32-1:0]     push_insn = '0;
  logic [FW*PC_W-1:0]   push_pc = '0;
  logic [FW*BPU_UPD_W-1:0] push_upd = '0;
  logic [FW-1:0]        push_exc = '0;
  logic                 push_ready;
  logic [IW-1:0]        pop_valid;
  logic [IW*32-1:0]     pop_insn;
  logic [IW*PC_W-1:0]   pop_pc;
  logic [IW*BPU_UPD_W-1:0] pop_upd;
  logic [IW-1:0]        pop_exc;
  logic [IW-1:0]        pop_ready = '0;
  logic [3:0]           count;

  int checks = 0;
  int errors = 0;

  fetch_buf #(
    .CONFIG_P_FETCH_WIDTH(1),
    .CONFIG_P_ISSUE_WIDTH(1),
    .CONFIG_P_DEPTH(3)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_insn(push_insn),
    .push_pc(push_pc), .push_upd(push_upd),
    .push_exc(push_exc), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_insn(pop_insn),
    .pop_pc(pop_pc), .pop_upd(pop_upd),
    .pop_exc(pop_exc), .pop_ready(pop_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [15:0] upd_of(input logic [31:0] pc);
    return {pc[7:0], ~pc[11:4]};
  endfunction

  task automatic drive(input logic [1:0] m, input logic [31:0] p0,
                       input logic [31:0] p1, input logic [1:0] e);
    push_valid = m;
    push_pc    = {p1, p0};
    push_insn  = {insn_of(p1), insn_of(p0)};
    push_upd   = {upd_of(p1), upd_of(p0)};
    push_exc   = e;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #12;
    checks++;
    if (count !== 4'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", count);
    end
    checks++;
    if (push_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", push_ready);
    end
    checks++;
    if (pop_valid !== 2'b00) begin
      errors++; $display("FAIL reset_pop_valid got %b exp 00", pop_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_pack();
    pop_ready = 2'b00;
    drive(2'b10, 32'h0, 32'h104, 2'b00);
    step();
    drive(2'b11, 32'h108, 32'h10C, 2'b10);
    step();
    push_valid = '0;
    checks++;
    if (count !== 4'd3) begin
      errors++; $display("FAIL pack_count got %0d exp 3", count);
    end
    checks++;
    if (pop_valid !== 2'b11) begin
      errors++; $display("FAIL pack_valid got %b exp 11", pop_valid);
    end
    checks++;
    if (pop_pc[31:0] !== 32'h104) begin
      errors++; $display("FAIL pack_pc0 got %h exp 104", pop_pc[31:0]);
    end
    checks++;
    if (pop_pc[63:32] !== 32'h108) begin
      errors++; $display("FAIL pack_pc1 got %h exp 108", pop_pc[63:32]);
    end
    checks++;
    if (pop_insn[31:0] !== insn_of(32'h104)) begin
      errors++; $display("FAIL pack_insn0 got %h exp %h",
                         pop_insn[31:0], insn_of(32'h104));
    end
    checks++;
    if (pop_exc !== 2'b00) begin
      errors++; $display("FAIL pack_exc got %b exp 00", pop_exc);
    end
    pop_ready = 2'b11;
    step();
    checks++;
    if (count !== 4'd1 || pop_valid !== 2'b01) begin
      errors++; $display("FAIL pack_pop2 got cnt %0d v %b exp 1 01",
                         count, pop_valid);
    end
    checks++;
    if (pop_pc[31:0] !== 32'h10C || pop_exc[0] !== 1'b1) begin
      errors++; $display("FAIL pack_tail got pc %h exc %b exp 10c 1",
                         pop_pc[31:0], pop_exc[0]);
    end
    step();
    checks++;
    if (count !== 4'd0 || pop_valid !== 2'b00) begin
      errors++; $display("FAIL pack_drain got cnt %0d v %b exp 0 00",
                         count, pop_valid);
    end
    pop_ready = 2'b00;
  endtask

  task automatic test_full();
    pop_ready = 2'b00;
    for (int r = 0; r < 3; r++) begin
      drive(2'b11, 32'h300 + 32'(8*r), 32'h304 + 32'(8*r), 2'b00);
      step();
    end
    checks++;
    if (count !== 4'd6 || push_ready !== 1'b1) begin
      errors++; $display("FAIL full_6 got cnt %0d rdy %b exp 6 1",
                         count, push_ready);
    end
    drive(2'b01, 32'h318, 32'h0, 2'b00);
    step();
    checks++;
    if (count !== 4'd7 || push_ready !== 1'b0) begin
      errors++; $display("FAIL full_7 got cnt %0d rdy %b exp 7 0",
                         count, push_ready);
    end
    drive(2'b11, 32'h500, 32'h504, 2'b00);
    step();
    push_valid = '0;
    checks++;
    if (count !== 4'd7) begin
      errors++; $display("FAIL full_hold got cnt %0d exp 7", count);
    end
    checks++;
    if (pop_pc[31:0] !== 32'h300) begin
      errors++; $display("FAIL full_head got %h exp 300", pop_pc[31:0]);
    end
    pop_ready = 2'b11;
    step(); step(); step();
    checks++;
    if (count !== 4'd1 || pop_pc[31:0] !== 32'h318) begin
      errors++; $display("FAIL full_last got cnt %0d pc %h exp 1 318",
                         count, pop_pc[31:0]);
    end
    step();
    checks++;
    if (count !== 4'd0) begin
      errors++; $display("FAIL full_drain got cnt %0d exp 0", count);
    end
    pop_ready = 2'b00;
  endtask

  task automatic test_wrap();
    logic [31:0] ep;
    pop_ready = 2'b00;
    drive(2'b11, 32'h1000, 32'h1004, 2'b00);
    step();
    for (int j = 0; j < 20; j++) begin
      drive(2'b11, 32'h1008 + 32'(8*j), 32'h100C + 32'(8*j), 2'b00);
      pop_ready = 2'b11;
      step();
      ep = 32'h1008 + 32'(8*j);
      checks++;
      if (count !== 4'd2) begin
        errors++; $display("FAIL wrap_count[%0d] got %0d exp 2", j, count);
      end
      checks++;
      if (pop_pc[31:0] !== ep) begin
        errors++; $display("FAIL wrap_pc0[%0d] got %h exp %h",
                           j, pop_pc[31:0], ep);
      end
      checks++;
      if (pop_pc[63:32] !== ep + 32'h4) begin
        errors++; $display("FAIL wrap_pc1[%0d] got %h exp %h",
                           j, pop_pc[63:32], ep + 32'h4);
      end
      checks++;
      if (pop_upd !== {upd_of(ep + 32'h4), upd_of(ep)}) begin
        errors++; $display("FAIL wrap_upd[%0d] got %h exp %h", j, pop_upd,
                           {upd_of(ep + 32'h4), upd_of(ep)});
      end
    end
    push_valid = '0;
    step();
    checks++;
    if (count !== 4'd0) begin
      errors++; $display("FAIL wrap_drain got %0d exp 0", count);
    end
    pop_ready = 2'b00;
  endtask

  task automatic test_pop_gap();
    drive(2'b11, 32'h400, 32'h404, 2'b00);
    step();
    push_valid = '0;
    pop_ready = 2'b10;
    step();
    checks++;
    if (count !== 4'd2 || pop_pc[31:0] !== 32'h400) begin
      errors++; $display("FAIL gap_hold got cnt %0d pc %h exp 2 400",
                         count, pop_pc[31:0]);
    end
    pop_ready = 2'b01;
    step();
    checks++;
    if (count !== 4'd1 || pop_pc[31:0] !== 32'h404) begin
      errors++; $display("FAIL gap_one got cnt %0d pc %h exp 1 404",
                         count, pop_pc[31:0]);
    end
    pop_ready = 2'b11;
    step();
    checks++;
    if (count !== 4'd0) begin
      errors++; $display("FAIL gap_drain got cnt %0d exp 0", count);
    end
    pop_ready = 2'b00;
  endtask

  task automatic test_flush();
    drive(2'b11, 32'h600, 32'h604, 2'b00);
    step();
    drive(2'b11, 32'h608, 32'h60C, 2'b00);
    step();
    drive(2'b01, 32'h610, 32'h0, 2'b00);
    step();
    push_valid = '0;
    checks++;
    if (count !== 4'd5) begin
      errors++; $display("FAIL flush_pre got cnt %0d exp 5", count);
    end
    flush = 1'b1;
    pop_ready = 2'b11;
    drive(2'b11, 32'h700, 32'h704, 2'b00);
    step();
    flush = 1'b0;
    push_valid = '0;
    pop_ready = 2'b00;
    checks++;
    if (count !== 4'd0 || pop_valid !== 2'b00 || push_ready !== 1'b1) begin
      errors++; $display("FAIL flush_empty got cnt %0d v %b rdy %b exp 0 00 1",
                         count, pop_valid, push_ready);
    end
    step();
    checks++;
    if (pop_valid !== 2'b00) begin
      errors++; $display("FAIL flush_idle got v %b exp 00", pop_valid);
    end
    drive(2'b01, 32'h200, 32'h0, 2'b00);
    step();
    push_valid = '0;
    checks++;
    if (pop_valid !== 2'b01 || pop_pc[31:0] !== 32'h200 ||
        count !== 4'd1) begin
      errors++; $display("FAIL flush_next got v %b pc %h cnt %0d exp 01 200 1",
                         pop_valid, pop_pc[31:0], count);
    end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_full();
    test_wrap();
    test_pop_gap();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
